// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: state encoding,
// key widths and the keypad decode helper.
package lock_pkg;

  localparam int unsigned KEY_W     = 4;
  localparam int unsigned KEY_IDX_W = 2;
  localparam int unsigned STATE_W   = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  // Index of the lowest asserted key in an active-high key vector.
  function automatic logic [KEY_IDX_W-1:0] key_index(input logic [KEY_W-1:0] low);
    key_index = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (low[i]) key_index = KEY_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad / code / status bundle between the lock controller and its host.
interface lock_ctrl_if #(
  parameter int unsigned CODE_LEN = 4
);
  import lock_pkg::*;

  logic [KEY_W-1:0]      key_n;
  logic [2*CODE_LEN-1:0] code_in;
  logic                  unlock;
  logic                  alarm;
  state_t                state;

  modport master (output key_n, output code_in,
                  input  unlock, input alarm, input state);
  modport slave  (input  key_n, input code_in,
                  output unlock, output alarm, output state);
endinterface

// File: rtl/lock_ctrl_key_event.sv
// Keypad sampler: registers the raw lines once and emits a one-cycle press
// pulse on an all-released -> any-pressed transition, with the decoded key.
module key_event
  import lock_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_W-1:0]     key_n_i,
  output logic                 press_o,
  output logic [KEY_IDX_W-1:0] key_idx_o,
  output logic                 multi_o
);

  logic [KEY_W-1:0]     key_q;
  logic                 press_q,   press_d;
  logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
  logic                 multi_q,   multi_d;
  logic [KEY_W-1:0]     low_c;

  // Edge detect and decode of the incoming keypad lines.
  always_comb begin
    low_c     = ~key_n_i;
    press_d   = (key_q == '1) && (key_n_i != '1);
    multi_d   = (low_c & (low_c - KEY_W'(1))) != '0;
    key_idx_d = key_index(low_c);
  end

  // Key register plus press pulse and latched decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q     <= '1;
      press_q   <= 1'b0;
      key_idx_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      key_q   <= key_n_i;
      press_q <= press_d;
      if (press_d) begin
        key_idx_q <= key_idx_d;
        multi_q   <= multi_d;
      end
    end
  end

  assign press_o   = press_q;
  assign key_idx_o = key_idx_q;
  assign multi_o   = multi_q;

endmodule

// File: rtl/lock_ctrl.sv
// Keypad code lock. Collects CODE_LEN presses, compares them with code_in
// and pulses unlock for OPEN_CYCLES on a match. Optional build macro
// LOCK_CTRL_LOCKOUT_EN adds a failed-tries counter and a LOCKOUT state that
// raises alarm and ignores keys for LOCK_CYCLES cycles.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned OPEN_CYCLES    = 16,
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  lock_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
  localparam int unsigned TMR_MAX_A = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_MAX = (TMR_MAX_A > TIMEOUT_CYCLES) ? TMR_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic                 press;
  logic [KEY_IDX_W-1:0] key_idx;
  logic                 key_multi;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 mism_q,   mism_d;
  logic [TMR_W-1:0]     tmr_q,    tmr_d;
  logic                 unlock_q, unlock_d;
  logic [KEY_IDX_W-1:0] digit_c;
  logic                 digit_miss_c;

`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  logic [TRY_W-1:0]     tries_q,  tries_d;
  logic                 alarm_q,  alarm_d;
`else
  logic                 unused_cfg;
  assign unused_cfg = ^{32'(MAX_TRIES)};
`endif

  key_event u_key_event (
    .clk       (clk),
    .reset     (reset),
    .key_n_i   (bus.key_n),
    .press_o   (press),
    .key_idx_o (key_idx),
    .multi_o   (key_multi)
  );

  // Stored code digit expected for the next press.
  always_comb begin
    digit_c = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (count_q == CNT_W'(i)) digit_c = bus.code_in[KEY_IDX_W*i +: KEY_IDX_W];
    end
    digit_miss_c = key_multi || (key_idx != digit_c);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mism_d   = mism_q;
    tmr_d    = tmr_q;
`ifdef LOCK_CTRL_LOCKOUT_EN
    tries_d  = tries_q;
`endif
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        mism_d  = 1'b0;
        tmr_d   = '0;
        if (press) begin
          count_d = CNT_W'(1);
          mism_d  = digit_miss_c;
          state_d = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (press) begin
          mism_d  = mism_q | digit_miss_c;
          count_d = count_q + CNT_W'(1);
          tmr_d   = '0;
          if (count_q == CNT_W'(CODE_LEN - 1)) state_d = ST_CHECK;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_FAIL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_CHECK: begin
        tmr_d   = '0;
        state_d = mism_q ? ST_FAIL : ST_OPEN;
      end
      ST_OPEN: begin
`ifdef LOCK_CTRL_LOCKOUT_EN
        tries_d = '0;
`endif
        if (tmr_q == TMR_W'(OPEN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FAIL: begin
        tmr_d   = '0;
        state_d = ST_IDLE;
`ifdef LOCK_CTRL_LOCKOUT_EN
        if (tries_q < TRY_W'(MAX_TRIES)) tries_d = tries_q + TRY_W'(1);
        if (tries_d == TRY_W'(MAX_TRIES)) state_d = ST_LOCKOUT;
`endif
      end
`ifdef LOCK_CTRL_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCK_CYCLES - 1)) begin
          tmr_d   = '0;
          tries_d = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`endif
      default: begin
        tmr_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Every return to IDLE starts the next entry from a clean slate.
    if (state_d == ST_IDLE) begin
      count_d = '0;
      mism_d  = 1'b0;
    end

    unlock_d = (state_d == ST_OPEN);
`ifdef LOCK_CTRL_LOCKOUT_EN
    alarm_d  = (state_d == ST_LOCKOUT);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      mism_q   <= 1'b0;
      tmr_q    <= '0;
      unlock_q <= 1'b0;
`ifdef LOCK_CTRL_LOCKOUT_EN
      tries_q  <= '0;
      alarm_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mism_q   <= mism_d;
      tmr_q    <= tmr_d;
      unlock_q <= unlock_d;
`ifdef LOCK_CTRL_LOCKOUT_EN
      tries_q  <= tries_d;
      alarm_q  <= alarm_d;
`endif
    end
  end

  assign bus.unlock = unlock_q;
  assign bus.state  = state_q;
`ifdef LOCK_CTRL_LOCKOUT_EN
  assign bus.alarm  = alarm_q;
`else
  assign bus.alarm  = 1'b0;
`endif

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: number of key presses per code entry.
REQ-002 SHALL have parameter MAX_TRIES, default 3: consecutive failed entries that trigger lockout.
REQ-003 SHALL have parameter OPEN_CYCLES, default 16: unlock pulse length in cycles.
REQ-004 SHALL have parameter LOCK_CYCLES, default 1024: lockout duration in cycles.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum idle gap between presses during entry.
REQ-006 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port key_n, input, 4 bits: keypad lines, one per key, active-low (0 = pressed).
REQ-009 SHALL have port code_in, input, 2*CODE_LEN bits: stored code as 2-bit key indices, digit 0 in bits [1:0].
REQ-010 SHALL have port unlock, output, 1 bit: registered door-open strobe.
REQ-011 SHALL have port alarm, output, 1 bit: registered lockout indicator.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-013 SHALL register key_n once and detect a press event only on the transition from all-high to any-low; a further press SHALL require return to all-high first.
REQ-014 SHALL decode a press with exactly one low bit to that key index; multiple low bits SHALL count as a digit that never matches.
REQ-015 SHALL implement states IDLE, ENTRY, CHECK, OPEN, FAIL and LOCKOUT.
REQ-016 In IDLE, a press SHALL move to ENTRY with digit count 1 and set the mismatch flag if the digit differs from code digit 0.
REQ-017 In ENTRY, each press SHALL compare against code digit[count], OR the result into the mismatch flag, and increment the count; on count reaching CODE_LEN the FSM SHALL go to CHECK.
REQ-018 In ENTRY, TIMEOUT_CYCLES cycles without a press SHALL force FAIL; the gap counter SHALL reload on every press.
REQ-019 CHECK SHALL last one cycle and go to OPEN if the mismatch flag is clear, otherwise to FAIL.
REQ-020 OPEN SHALL hold unlock=1 for exactly OPEN_CYCLES cycles, clear the tries counter, then return to IDLE; presses in OPEN SHALL be ignored.
REQ-021 FAIL SHALL last one cycle, increment tries (saturating at MAX_TRIES), and go to IDLE, or to LOCKOUT when tries reaches MAX_TRIES.
REQ-022 Latency: unlock SHALL rise at the second rising edge after the edge that samples the final key press.
REQ-023 Mismatch flag and digit count SHALL clear on every entry into IDLE.

Reset
REQ-024 While reset=0 at a rising edge: state=IDLE, unlock=0, alarm=0, tries=0, all counters=0, key register=4'hF.
REQ-025 Reset mid-entry, mid-OPEN or mid-LOCKOUT SHALL abort at that edge with no partial state kept.

Configuration
REQ-026 Macro LOCK_CTRL_LOCKOUT_EN defined: tries counter, LOCKOUT state and alarm SHALL be implemented; in LOCKOUT, alarm=1 and keys are ignored for LOCK_CYCLES cycles, after which tries clears and the FSM returns to IDLE.
REQ-027 Macro LOCK_CTRL_LOCKOUT_EN undefined: no tries counter and no LOCKOUT state; FAIL SHALL always go to IDLE and alarm SHALL be tied to 0.

Structure
REQ-028 A shared package lock_pkg SHALL hold the state typedef/encoding (IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5) and the key-index width constant.
REQ-029 Press detection and decode SHALL be a sub-module key_event (outputs: press pulse, key index, multi-key flag).

Verification (CODE_LEN=4, code_in=8'b11_10_01_00)
REQ-030 Keys 0,1,2,3 each pressed and released -> unlock=1 for exactly 16 cycles starting at the second edge after the last press; tries=0.
REQ-031 Keys 0,1,3,3 -> CHECK then FAIL, unlock stays 0, tries=1, FSM returns to IDLE.
REQ-032 Three wrong entries with LOCK_CTRL_LOCKOUT_EN defined -> alarm=1 for 1024 cycles and presses ignored, then IDLE with tries=0; with the macro undefined -> alarm stays 0.
REQ-033 Keys 0,1, then no press for 4096 cycles -> FAIL; key 0 together with key 1 as digit 0 -> entry fails after 4 presses.
REQ-034 reset=0 asserted on cycle 5 of OPEN -> unlock=0 and state=IDLE at that edge; correct entry after reset release -> unlocks normally.
